// File: rtl/sound_source_arbiter_if.sv
// rtl/sound_source_arbiter_if.sv - melody-source request/note bus and granted tone-decoder outputs
interface sound_source_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]   req;
  logic [4*N_SRC-1:0] note_bus;
  logic [N_SRC-1:0]   grant;
  logic [3:0]         note_num;
  logic               enable_sound;
  logic               busy;

  modport master (
    output req, note_bus,
    input  grant, note_num, enable_sound, busy
  );

  modport slave (
    input  req, note_bus,
    output grant, note_num, enable_sound, busy
  );
endinterface

// File: rtl/sound_source_arbiter.sv
// rtl/sound_source_arbiter.sv - fixed-priority tone-generator arbiter with silent gap and hold timeout
// Optional direct preemption by higher-priority sources: define SOUND_PREEMPT_EN.
module sound_source_arbiter #(
  parameter int N_SRC     = 4,
  parameter int GAP_TICKS = 1,
  parameter int MAX_TICKS = 12
) (
  input  logic clk,
  input  logic resetN,
  input  logic slowClken,
  sound_source_arbiter_if.slave bus
);

  localparam int MAXV = (MAX_TICKS > GAP_TICKS) ? MAX_TICKS : GAP_TICKS;
  localparam int CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);
  localparam int OW   = (N_SRC < 2) ? 1 : $clog2(N_SRC);
  localparam logic [3:0] NOTE_SILENT = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t           state, state_n;
  logic [N_SRC-1:0] grant_q, grant_n;
  logic [N_SRC-1:0] lockout, lockout_n;
  logic [N_SRC-1:0] eligible;
  logic [3:0]       note_q, note_n;
  logic             en_q;
  logic [CW-1:0]    hold_cnt, hold_n;
  logic [CW-1:0]    gap_cnt, gap_n;
  logic [OW-1:0]    owner, owner_n;
  logic [OW-1:0]    winner;
  logic             any_elig;
  logic             timeout;
  logic             gap_done;

  function automatic logic [3:0] lane(input logic [4*N_SRC-1:0] nb, input logic [OW-1:0] idx);
    return nb[4*int'(idx) +: 4];
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign eligible = bus.req & ~lockout;

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner   = OW'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign timeout  = (MAX_TICKS != 0) && slowClken && (int'(hold_cnt) == MAX_TICKS - 1);
  assign gap_done = (int'(gap_cnt) >= GAP_TICKS);

  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    note_n    = note_q;
    hold_n    = hold_cnt;
    gap_n     = gap_cnt;
    owner_n   = owner;
    lockout_n = lockout & bus.req;
    case (state)
      S_IDLE: begin
        if (any_elig) begin
          state_n = S_GRANT;
          owner_n = winner;
          grant_n = N_SRC'(1) << winner;
          note_n  = lane(bus.note_bus, winner);
          hold_n  = '0;
          gap_n   = '0;
        end
      end
      S_GRANT: begin
        // A release in the timeout clk wins, so the owner is not locked out.
        if (!bus.req[owner] || timeout) begin
          state_n = S_GAP;
          grant_n = '0;
          note_n  = NOTE_SILENT;
          hold_n  = '0;
          gap_n   = '0;
          if (bus.req[owner]) lockout_n[owner] = 1'b1;
        end
`ifdef SOUND_PREEMPT_EN
        else if (any_elig && (winner < owner)) begin
          owner_n = winner;
          grant_n = N_SRC'(1) << winner;
          note_n  = lane(bus.note_bus, winner);
          hold_n  = '0;
        end
`endif
        else begin
          note_n = lane(bus.note_bus, owner);
          if (slowClken) hold_n = sat_inc(hold_cnt);
        end
      end
      S_GAP: begin
        if (gap_done) begin
          if (any_elig) begin
            state_n = S_GRANT;
            owner_n = winner;
            grant_n = N_SRC'(1) << winner;
            note_n  = lane(bus.note_bus, winner);
            hold_n  = '0;
            gap_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else if (slowClken) begin
          gap_n = sat_inc(gap_cnt);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_IDLE;
      grant_q  <= '0;
      note_q   <= NOTE_SILENT;
      en_q     <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      owner    <= '0;
      lockout  <= '0;
    end else begin
      state    <= state_n;
      grant_q  <= grant_n;
      note_q   <= note_n;
      en_q     <= |grant_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      owner    <= owner_n;
      lockout  <= lockout_n;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.note_num     = note_q;
  assign bus.enable_sound = en_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_sound_source_arbiter.sv
// tb/tb_sound_source_arbiter.sv - vector table and corner sequences for sound_source_arbiter
module tb_sound_source_arbiter;

  localparam logic [15:0] NB = 16'h7531;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic slowClken = 1'b0;

  sound_source_arbiter_if #(.N_SRC(4)) sif ();

  sound_source_arbiter #(.N_SRC(4), .GAP_TICKS(1), .MAX_TICKS(12)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .slowClken (slowClken),
    .bus       (sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] notes;
    logic        slow;
    logic [3:0]  grant;
    logic [3:0]  note;
    logic        en;
    logic        busy;
  } vec_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] note;
    logic       en;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] nb, input logic s,
                      input logic [3:0] eg, input logic [3:0] enote, input logic een,
                      input logic ebusy, input string tag);
    exp_t e;
    sif.req      = r;
    sif.note_bus = nb;
    slowClken    = s;
    sb.push_back('{grant: eg, note: enote, en: een, busy: ebusy});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(sif.grant), 32'(e.grant));
    chk({tag, "_note"}, 32'(sif.note_num), 32'(e.note));
    chk({tag, "_en"}, 32'(sif.enable_sound), 32'(e.en));
    chk({tag, "_busy"}, 32'(sif.busy), 32'(e.busy));
  endtask

  task automatic hs(input logic [3:0] r, input logic s, input logic [3:0] eg,
                    input logic [3:0] enote, input logic ebusy, input string tag);
    step(r, NB, s, eg, enote, (eg != 4'b0000), ebusy, tag);
  endtask

  initial begin
    tbl[0]  = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, NB,       1'b0, 4'b0100, 4'd5,  1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 16'h7731, 1'b0, 4'b0100, 4'd7,  1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 16'h7731, 1'b0, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[4]  = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[5]  = '{4'b0000, NB,       1'b1, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[6]  = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b0};
    tbl[7]  = '{4'b0110, NB,       1'b0, 4'b0010, 4'd3,  1'b1, 1'b1};
    tbl[8]  = '{4'b0100, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[9]  = '{4'b0100, NB,       1'b1, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[10] = '{4'b0100, NB,       1'b0, 4'b0100, 4'd5,  1'b1, 1'b1};
    tbl[11] = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[12] = '{4'b0000, NB,       1'b1, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b0};
    tbl[14] = '{4'b0001, NB,       1'b0, 4'b0001, 4'd1,  1'b1, 1'b1};
    tbl[15] = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[16] = '{4'b0000, NB,       1'b1, 4'b0000, 4'd13, 1'b0, 1'b1};
    tbl[17] = '{4'b0000, NB,       1'b0, 4'b0000, 4'd13, 1'b0, 1'b0};

    sif.req      = 4'b0000;
    sif.note_bus = NB;

    @(negedge clk);
    chk("rst_grant", 32'(sif.grant), 32'h0);
    chk("rst_note", 32'(sif.note_num), 32'd13);
    chk("rst_en", 32'(sif.enable_sound), 32'h0);
    chk("rst_busy", 32'(sif.busy), 32'h0);
    resetN = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].req, tbl[i].notes, tbl[i].slow, tbl[i].grant, tbl[i].note,
           tbl[i].en, tbl[i].busy, $sformatf("vec%0d", i));
    end

    // Timeout: 12th tick releases, locked source stays out until it drops req.
    hs(4'b1000, 1'b0, 4'b1000, 4'd7, 1'b1, "t4_grant");
    for (int k = 1; k <= 11; k++) begin
      hs(4'b1000, 1'b0, 4'b1000, 4'd7, 1'b1, $sformatf("t4_q%0d", k));
      hs(4'b1000, 1'b1, 4'b1000, 4'd7, 1'b1, $sformatf("t4_tick%0d", k));
    end
    hs(4'b1000, 1'b0, 4'b1000, 4'd7,  1'b1, "t4_q12");
    hs(4'b1000, 1'b1, 4'b0000, 4'd13, 1'b1, "t4_timeout");
    hs(4'b1000, 1'b1, 4'b0000, 4'd13, 1'b1, "t4_gap");
    hs(4'b1000, 1'b0, 4'b0000, 4'd13, 1'b0, "t4_locked0");
    hs(4'b1000, 1'b1, 4'b0000, 4'd13, 1'b0, "t4_locked1");
    hs(4'b1000, 1'b0, 4'b0000, 4'd13, 1'b0, "t4_locked2");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b0, "t4_drop");
    hs(4'b1000, 1'b0, 4'b1000, 4'd7,  1'b1, "t4_regrant");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b1, "t4_rel");
    hs(4'b0000, 1'b1, 4'b0000, 4'd13, 1'b1, "t4_gap2");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b0, "t4_idle");

    // Release on the timeout tick: no lockout, re-raised req wins at gap exit.
    hs(4'b0010, 1'b0, 4'b0010, 4'd3, 1'b1, "t6_grant");
    for (int k = 1; k <= 11; k++) begin
      hs(4'b0010, 1'b1, 4'b0010, 4'd3, 1'b1, $sformatf("t6_tick%0d", k));
    end
    hs(4'b0000, 1'b1, 4'b0000, 4'd13, 1'b1, "t6_rel_tick");
    hs(4'b0010, 1'b1, 4'b0000, 4'd13, 1'b1, "t6_gap");
    hs(4'b0010, 1'b0, 4'b0010, 4'd3,  1'b1, "t6_regrant");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b1, "t6_rel");
    hs(4'b0000, 1'b1, 4'b0000, 4'd13, 1'b1, "t6_gap2");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b0, "t6_idle");

    // Higher-priority request while source 2 owns the generator.
    hs(4'b0100, 1'b0, 4'b0100, 4'd5, 1'b1, "t5_grant");
`ifdef SOUND_PREEMPT_EN
    hs(4'b0101, 1'b0, 4'b0001, 4'd1,  1'b1, "t5_preempt");
    hs(4'b0101, 1'b0, 4'b0001, 4'd1,  1'b1, "t5_hold");
    hs(4'b0100, 1'b0, 4'b0000, 4'd13, 1'b1, "t5_rel");
    hs(4'b0100, 1'b1, 4'b0000, 4'd13, 1'b1, "t5_gap");
    hs(4'b0100, 1'b0, 4'b0100, 4'd5,  1'b1, "t5_back");
`else
    hs(4'b0101, 1'b0, 4'b0100, 4'd5,  1'b1, "t5_wait0");
    hs(4'b0101, 1'b1, 4'b0100, 4'd5,  1'b1, "t5_wait1");
    hs(4'b0001, 1'b0, 4'b0000, 4'd13, 1'b1, "t5_rel");
    hs(4'b0001, 1'b1, 4'b0000, 4'd13, 1'b1, "t5_gap");
    hs(4'b0001, 1'b0, 4'b0001, 4'd1,  1'b1, "t5_next");
`endif
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b1, "t5_rel2");
    hs(4'b0000, 1'b1, 4'b0000, 4'd13, 1'b1, "t5_gap2");
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b0, "t5_idle");

    // Asynchronous reset in the middle of a grant.
    hs(4'b0010, 1'b0, 4'b0010, 4'd3, 1'b1, "t1_grant");
    #2 resetN = 1'b0;
    #1;
    chk("t1_async_grant", 32'(sif.grant), 32'h0);
    chk("t1_async_note", 32'(sif.note_num), 32'd13);
    chk("t1_async_en", 32'(sif.enable_sound), 32'h0);
    chk("t1_async_busy", 32'(sif.busy), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    hs(4'b0000, 1'b0, 4'b0000, 4'd13, 1'b0, "t1_idle");
    hs(4'b0010, 1'b0, 4'b0010, 4'd3,  1'b1, "t1_regrant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
